// File: rtl/ysyx_22040759_mem_stage_pkg.sv
// Shared encodings and bus layouts for the MEM stage and its load aligner.
package ysyx_22040759_mem_stage_pkg;

    localparam int ES_BUS_WIDTH = 205;
    localparam int MS_BUS_WIDTH = 200;
    localparam int FWD_WIDTH    = 70;

    // WB write-back source select
    localparam logic [1:0] WREG_ALU = 2'd0;
    localparam logic [1:0] WREG_MEM = 2'd1;
    localparam logic [1:0] WREG_PC4 = 2'd2;

    // Access size
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,
        MS_REQ  = 2'd1,
        MS_WAIT = 2'd2,
        MS_DONE = 2'd3
    } ms_state_e;

    // EX -> MEM bus, MSB first
    typedef struct packed {
        logic        reg_wen;
        logic [4:0]  rd;
        logic [1:0]  wreg_sel;
        logic        mem_re;
        logic        mem_we;
        logic [1:0]  size;
        logic        uns;
        logic [63:0] st_data;
        logic [63:0] alu_res;
        logic [63:0] pc;
    } es_bus_t;

    // Byte enables of an aligned access of the given size
    function automatic logic [7:0] size_mask(input logic [1:0] size);
        case (size)
            SZ_B:    return 8'h01;
            SZ_H:    return 8'h03;
            SZ_W:    return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_22040759_mem_stage_if.sv
// Data-memory request/response port (req/gnt/rvalid).
interface ysyx_22040759_mem_stage_if;

    logic        dmem_req;
    logic        dmem_we;
    logic [63:0] dmem_addr;
    logic [63:0] dmem_wdata;
    logic [7:0]  dmem_wmask;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [63:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wmask,
        input  dmem_gnt, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wmask,
        output dmem_gnt, dmem_rvalid, dmem_rdata
    );

endinterface

// File: rtl/ysyx_22040759_mem_stage_ld_align.sv
// Combinational load extract/extend: shifts the raw 8-byte word down to the
// addressed byte, keeps 8/16/32/64 bits and zero- or sign-extends to 64 bits.
module ysyx_22040759_ld_align
    import ysyx_22040759_mem_stage_pkg::*;
(
    input  logic [63:0] raw,
    input  logic [2:0]  off,
    input  logic [1:0]  size,
    input  logic        uns,
    output logic [63:0] data
);

    logic [63:0] sh;

    // Shift to the addressed byte, then select width and extension
    always_comb begin
        sh = raw >> {off, 3'b000};
        case (size)
            SZ_B:    data = uns ? {56'd0, sh[7:0]}  : {{56{sh[7]}},  sh[7:0]};
            SZ_H:    data = uns ? {48'd0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
            SZ_W:    data = uns ? {32'd0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
            default: data = sh;
        endcase
    end

endmodule

// File: rtl/ysyx_22040759_mem_stage.sv
// MEM pipeline stage: latches the EX bus, issues one load/store on the
// req/gnt/rvalid port, aligns load data and hands the result to WB.
// Optional feature macro: MS_FWD_EN (adds ms_to_ds_fwd and ms_load_busy).
module ysyx_22040759_mem_stage
    import ysyx_22040759_mem_stage_pkg::*;
#(
    parameter int ES_BUS_W = ES_BUS_WIDTH,
    parameter int MS_BUS_W = MS_BUS_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                es_to_ms_valid,
    input  logic [ES_BUS_W-1:0] es_to_ms_bus,
    output logic                ms_allowin,
    input  logic                ws_allowin,
    output logic                ms_to_ws_valid,
    output logic [MS_BUS_W-1:0] ms_to_ws_bus,
`ifdef MS_FWD_EN
    output logic [FWD_WIDTH-1:0] ms_to_ds_fwd,
    output logic                 ms_load_busy,
`endif
    ysyx_22040759_mem_stage_if.master dmem
);

    es_bus_t     es_bus;
    es_bus_t     bus_q, bus_d;
    logic        ms_valid_q, ms_valid_d;
    ms_state_e   state_q, state_d;
    logic        req_q, req_d;
    logic [63:0] rdata_q, rdata_d;
    logic [63:0] ld_data;
    logic [63:0] rdata_out;
    logic [15:0] wmask_wide;
    logic        is_mem, is_store, is_load, new_is_mem, ms_ready_go;

    assign es_bus     = es_bus_t'(es_to_ms_bus);
    assign is_store   = bus_q.mem_we;
    assign is_load    = bus_q.mem_re && !bus_q.mem_we;
    assign is_mem     = bus_q.mem_re || bus_q.mem_we;
    assign new_is_mem = es_bus.mem_re || es_bus.mem_we;

    assign ms_ready_go    = !is_mem || (state_q == MS_DONE);
    assign ms_allowin     = !ms_valid_q || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid_q && ms_ready_go;

    ysyx_22040759_ld_align u_ld_align (
        .raw  (dmem.dmem_rdata),
        .off  (bus_q.alu_res[2:0]),
        .size (bus_q.size),
        .uns  (bus_q.uns),
        .data (ld_data)
    );

    // Next-state: access FSM, then stage hand-over (which restarts the FSM)
    always_comb begin
        ms_valid_d = ms_valid_q;
        state_d    = state_q;
        bus_d      = bus_q;
        rdata_d    = rdata_q;
        if (ms_valid_q) begin
            case (state_q)
                MS_REQ:  if (dmem.dmem_gnt) state_d = is_store ? MS_DONE : MS_WAIT;
                MS_WAIT: if (dmem.dmem_rvalid) begin
                    rdata_d = ld_data;
                    state_d = MS_DONE;
                end
                default: ;
            endcase
        end
        if (ms_allowin) begin
            ms_valid_d = es_to_ms_valid;
            state_d    = MS_IDLE;
            if (es_to_ms_valid) begin
                bus_d = es_bus;
                if (new_is_mem) state_d = MS_REQ;
            end
        end
        req_d = (state_d == MS_REQ);
    end

    // Control state; reset returns the stage to empty/IDLE mid-access
    always_ff @(posedge clk) begin
        if (!rst) begin
            ms_valid_q <= 1'b0;
            state_q    <= MS_IDLE;
            req_q      <= 1'b0;
        end else begin
            ms_valid_q <= ms_valid_d;
            state_q    <= state_d;
            req_q      <= req_d;
        end
    end

    // Instruction bus and captured load data carry no reset
    always_ff @(posedge clk) begin
        bus_q   <= bus_d;
        rdata_q <= rdata_d;
    end

    // Memory request fields; bytes past the 8-byte boundary are dropped
    always_comb begin
        wmask_wide       = {8'h00, size_mask(bus_q.size)} << bus_q.alu_res[2:0];
        dmem.dmem_req    = req_q;
        dmem.dmem_we     = is_store;
        dmem.dmem_addr   = {bus_q.alu_res[63:3], 3'b000};
        dmem.dmem_wdata  = bus_q.st_data << {bus_q.alu_res[2:0], 3'b000};
        dmem.dmem_wmask  = is_store ? wmask_wide[7:0] : 8'h00;
        rdata_out        = is_load ? rdata_q : 64'd0;
        ms_to_ws_bus     = {bus_q.reg_wen, bus_q.rd, bus_q.wreg_sel,
                            rdata_out, bus_q.alu_res, bus_q.pc};
    end

`ifdef MS_FWD_EN
    logic [63:0] wb_value;

    // Same write-back value selection WB applies
    always_comb begin
        case (bus_q.wreg_sel)
            WREG_PC4: wb_value = bus_q.pc + 64'd4;
            WREG_MEM: wb_value = rdata_out;
            default:  wb_value = bus_q.alu_res;
        endcase
        ms_to_ds_fwd = {ms_valid_q && bus_q.reg_wen && ms_ready_go, bus_q.rd, wb_value};
        ms_load_busy = ms_valid_q && bus_q.mem_re && !ms_ready_go;
    end
`endif

endmodule

// File: tb/tb_ysyx_22040759_mem_stage.sv
// Bench for the MEM stage: vector table run through a scoreboard, plus
// hand-written WB-stall and reset-mid-access sequences.
module tb_ysyx_22040759_mem_stage;
    import ysyx_22040759_mem_stage_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         es_to_ms_valid;
    logic [204:0] es_to_ms_bus;
    logic         ms_allowin;
    logic         ws_allowin;
    logic         ms_to_ws_valid;
    logic [199:0] ms_to_ws_bus;
`ifdef MS_FWD_EN
    logic [69:0]  ms_to_ds_fwd;
    logic         ms_load_busy;
`endif

    ysyx_22040759_mem_stage_if dmem_if();

    ysyx_22040759_mem_stage dut (
        .clk            (clk),
        .rst            (rst),
        .es_to_ms_valid (es_to_ms_valid),
        .es_to_ms_bus   (es_to_ms_bus),
        .ms_allowin     (ms_allowin),
        .ws_allowin     (ws_allowin),
        .ms_to_ws_valid (ms_to_ws_valid),
        .ms_to_ws_bus   (ms_to_ws_bus),
`ifdef MS_FWD_EN
        .ms_to_ds_fwd   (ms_to_ds_fwd),
        .ms_load_busy   (ms_load_busy),
`endif
        .dmem           (dmem_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        re, we;
        logic [1:0]  size;
        logic        uns;
        logic [63:0] st_data, alu, pc;
        logic [4:0]  rd;
        logic        wen;
        logic [1:0]  sel;
        int          gnt_dly, rv_dly;
        logic [63:0] mem_rdata, exp_addr, exp_wdata;
        logic [7:0]  exp_wmask;
        logic [63:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic [199:0] bus;
        int           lat;
        int           c0;
    } sb_t;

    sb_t  sb[$];
    sb_t  mon_e;
    vec_t vt[12];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   pops  = 0;

    localparam logic [63:0] JUNK = 64'hA5A5_5A5A_DEAD_0000;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic re, input logic we, input logic [1:0] size,
                                 input logic uns, input logic [63:0] st, input logic [63:0] alu,
                                 input logic [63:0] pc, input logic [4:0] rd, input logic [1:0] sel,
                                 input int gd, input int rv, input logic [63:0] mrd,
                                 input logic [63:0] eaddr, input logic [63:0] ewd,
                                 input logic [7:0] emask, input logic [63:0] erd, input int lat);
        vec_t v;
        v.re = re; v.we = we; v.size = size; v.uns = uns; v.st_data = st; v.alu = alu;
        v.pc = pc; v.rd = rd; v.wen = !we; v.sel = sel; v.gnt_dly = gd; v.rv_dly = rv;
        v.mem_rdata = mrd; v.exp_addr = eaddr; v.exp_wdata = ewd; v.exp_wmask = emask;
        v.exp_rdata = erd; v.exp_lat = lat;
        return v;
    endfunction

    function automatic logic [204:0] mk_in(input vec_t v);
        return {v.wen, v.rd, v.sel, v.re, v.we, v.size, v.uns, v.st_data, v.alu, v.pc};
    endfunction

    function automatic logic [199:0] mk_exp(input vec_t v);
        return {v.wen, v.rd, v.sel, v.exp_rdata, v.alu, v.pc};
    endfunction

    // Scoreboard: every WB transfer pops one expected entry
    always @(negedge clk) begin
        if (rst && ms_to_ws_valid && ws_allowin) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: got %0h expected no transfer", ms_to_ws_bus);
            end else begin
                mon_e = sb.pop_front();
                chk("ws_bus", ms_to_ws_bus, mon_e.bus);
                if (mon_e.lat > 0) chk("latency", cyc - mon_e.c0 + 1, mon_e.lat);
            end
            pops++;
        end
    end

    // Memory side of one access: check request, grant after stall, return data
    task automatic service(input vec_t v);
        int n = 0;
        @(negedge clk);
        while (!dmem_if.dmem_req && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("dmem_req", dmem_if.dmem_req, 1'b1);
        if (!dmem_if.dmem_req) return;
        chk("dmem_addr", dmem_if.dmem_addr, v.exp_addr);
        chk("dmem_we", dmem_if.dmem_we, v.we);
        chk("dmem_wmask", dmem_if.dmem_wmask, v.exp_wmask);
        chk("dmem_wdata", dmem_if.dmem_wdata, v.exp_wdata);
        for (int i = 0; i < v.gnt_dly; i++) begin
            @(negedge clk);
            chk("req_hold", dmem_if.dmem_req, 1'b1);
            chk("addr_hold", dmem_if.dmem_addr, v.exp_addr);
        end
        dmem_if.dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_if.dmem_gnt = 1'b0;
        chk("req_drop", dmem_if.dmem_req, 1'b0);
        if (v.re && !v.we) begin
            for (int i = 1; i < v.rv_dly; i++) @(negedge clk);
            dmem_if.dmem_rvalid = 1'b1;
            dmem_if.dmem_rdata  = v.mem_rdata;
            @(negedge clk);
            dmem_if.dmem_rvalid = 1'b0;
            dmem_if.dmem_rdata  = JUNK;
        end
    endtask

    task automatic wait_out(input int p0);
        int n = 0;
        while (pops == p0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("output_seen", pops > p0, 1'b1);
    endtask

    task automatic present(input vec_t v);
        @(posedge clk);
        #1;
        es_to_ms_bus   = mk_in(v);
        es_to_ms_valid = 1'b1;
        @(negedge clk);
        chk("ms_allowin", ms_allowin, 1'b1);
        @(posedge clk);
        #1;
        es_to_ms_valid = 1'b0;
        es_to_ms_bus   = '1;
        sb.push_back('{mk_exp(v), v.exp_lat, cyc});
    endtask

    task automatic run_vec(input vec_t v);
        int p0 = pops;
        present(v);
        if (v.re || v.we) service(v);
        wait_out(p0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t va, vb, vc;
        int   p0;

        //        re we size uns st_data                 alu                     pc            rd    sel   gd rv mem_rdata               exp_addr      exp_wdata               mask   exp_rdata               lat
        vt[0]  = mkv(0, 0, SZ_B, 0, 64'h0,                  64'h1234_5678_9ABC_DEF0, 64'h8000_0000, 5'd5,  2'd0, 0, 0, 64'h0,                  64'h0,        64'h0,                  8'h00, 64'h0,                  1);
        vt[1]  = mkv(0, 1, SZ_D, 0, 64'h1122_3344_5566_7788, 64'h1000,               64'h8000_0004, 5'd0,  2'd0, 0, 0, 64'h0,                  64'h1000,     64'h1122_3344_5566_7788, 8'hFF, 64'h0,                  2);
        vt[2]  = mkv(1, 0, SZ_B, 0, 64'h0,                  64'h1003,               64'h8000_0008, 5'd10, 2'd1, 2, 3, 64'h0000_0000_8000_0000, 64'h1000,     64'h0,                  8'h00, 64'hFFFF_FFFF_FFFF_FF80, 7);
        vt[3]  = mkv(1, 0, SZ_B, 1, 64'h0,                  64'h1003,               64'h8000_000C, 5'd11, 2'd1, 2, 3, 64'h0000_0000_8000_0000, 64'h1000,     64'h0,                  8'h00, 64'h80,                 7);
        vt[4]  = mkv(0, 1, SZ_H, 0, 64'hBEEF,               64'h1006,               64'h8000_0010, 5'd0,  2'd0, 0, 0, 64'h0,                  64'h1000,     64'hBEEF_0000_0000_0000, 8'hC0, 64'h0,                  2);
        vt[5]  = mkv(1, 0, SZ_W, 0, 64'h0,                  64'h2004,               64'h8000_0014, 5'd12, 2'd1, 0, 1, 64'h8765_4321_0000_0000, 64'h2000,     64'h0,                  8'h00, 64'hFFFF_FFFF_8765_4321, 3);
        vt[6]  = mkv(1, 0, SZ_H, 1, 64'h0,                  64'h2002,               64'h8000_0018, 5'd13, 2'd1, 1, 2, 64'h0000_BEEF_CAFE_0000, 64'h2000,     64'h0,                  8'h00, 64'hCAFE,               5);
        vt[7]  = mkv(1, 0, SZ_H, 0, 64'h0,                  64'h2002,               64'h8000_001C, 5'd14, 2'd1, 0, 1, 64'h0000_BEEF_CAFE_0000, 64'h2000,     64'h0,                  8'h00, 64'hFFFF_FFFF_FFFF_CAFE, 3);
        vt[8]  = mkv(1, 0, SZ_D, 0, 64'h0,                  64'h3000,               64'h8000_0020, 5'd15, 2'd1, 0, 1, 64'hDEAD_BEEF_0123_4567, 64'h3000,     64'h0,                  8'h00, 64'hDEAD_BEEF_0123_4567, 3);
        vt[9]  = mkv(0, 1, SZ_W, 0, 64'hAABB_CCDD,          64'h1006,               64'h8000_0024, 5'd0,  2'd0, 1, 0, 64'h0,                  64'h1000,     64'hCCDD_0000_0000_0000, 8'hC0, 64'h0,                  3);
        vt[10] = mkv(1, 1, SZ_D, 0, 64'h0102_0304_0506_0708, 64'h4008,               64'h8000_0028, 5'd0,  2'd0, 0, 0, 64'h0,                  64'h4008,     64'h0102_0304_0506_0708, 8'hFF, 64'h0,                  2);
        vt[11] = mkv(1, 0, SZ_W, 1, 64'h0,                  64'h2004,               64'h8000_002C, 5'd16, 2'd1, 0, 1, 64'h8765_4321_0000_0000, 64'h2000,     64'h0,                  8'h00, 64'h8765_4321,          3);

        es_to_ms_valid      = 1'b0;
        es_to_ms_bus        = '1;
        ws_allowin          = 1'b1;
        dmem_if.dmem_gnt    = 1'b0;
        dmem_if.dmem_rvalid = 1'b0;
        dmem_if.dmem_rdata  = JUNK;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_valid", ms_to_ws_valid, 1'b0);
        chk("rst_req", dmem_if.dmem_req, 1'b0);
        chk("rst_allowin", ms_allowin, 1'b1);
        @(posedge clk);
        #1 rst = 1'b1;

        for (int i = 0; i < 12; i++) run_vec(vt[i]);

        // WB stall holds a finished load, then a back-to-back load goes in
        va = mkv(1, 0, SZ_D, 0, 64'h0, 64'h5000, 64'h8000_0100, 5'd20, 2'd1, 0, 1,
                 64'h0123_4567_89AB_CDEF, 64'h5000, 64'h0, 8'h00, 64'h0123_4567_89AB_CDEF, 0);
        vb = mkv(1, 0, SZ_B, 1, 64'h0, 64'h5001, 64'h8000_0104, 5'd21, 2'd1, 0, 1,
                 64'h0000_0000_0000_AB00, 64'h5000, 64'h0, 8'h00, 64'hAB, 3);
        p0 = pops;
        @(posedge clk);
        #1 ws_allowin = 1'b0;
        present(va);
        service(va);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid", ms_to_ws_valid, 1'b1);
            chk("stall_bus", ms_to_ws_bus, mk_exp(va));
            chk("stall_allowin", ms_allowin, 1'b0);
            chk("stall_req", dmem_if.dmem_req, 1'b0);
        end
        @(posedge clk);
        #1;
        es_to_ms_bus   = mk_in(vb);
        es_to_ms_valid = 1'b1;
        @(negedge clk);
        chk("stall_block", ms_allowin, 1'b0);
        chk("stall_no_pop", pops, p0);
        @(posedge clk);
        #1 ws_allowin = 1'b1;
        @(negedge clk);
        chk("release_allowin", ms_allowin, 1'b1);
        @(posedge clk);
        #1;
        es_to_ms_valid = 1'b0;
        es_to_ms_bus   = '1;
        sb.push_back('{mk_exp(vb), vb.exp_lat, cyc});
        service(vb);
        wait_out(p0 + 1);

        // Reset during WAIT; a late rvalid must be ignored
        vc = mkv(1, 0, SZ_W, 0, 64'h0, 64'h6000, 64'h8000_0200, 5'd22, 2'd1, 0, 1,
                 64'h1111_2222_3333_4444, 64'h6000, 64'h0, 8'h00, 64'h3333_4444, 3);
        present(vc);
        @(negedge clk);
        chk("rst6_req", dmem_if.dmem_req, 1'b1);
        dmem_if.dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_if.dmem_gnt = 1'b0;
        chk("rst6_wait_req", dmem_if.dmem_req, 1'b0);
        chk("rst6_wait_valid", ms_to_ws_valid, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst6_req_off", dmem_if.dmem_req, 1'b0);
        chk("rst6_valid_off", ms_to_ws_valid, 1'b0);
        chk("rst6_allowin", ms_allowin, 1'b1);
        sb.delete();
        rst = 1'b1;
        dmem_if.dmem_rvalid = 1'b1;
        dmem_if.dmem_rdata  = vc.mem_rdata;
        @(negedge clk);
        dmem_if.dmem_rvalid = 1'b0;
        dmem_if.dmem_rdata  = JUNK;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("late_rvalid_valid", ms_to_ws_valid, 1'b0);
            chk("late_rvalid_req", dmem_if.dmem_req, 1'b0);
        end

        // Stage still works after the reset
        run_vec(vt[0]);
        run_vec(vt[5]);

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
